// File: rtl/multi_clk_divider_pkg.sv
// Shared types, defaults and clamp helpers for the multi-channel clock divider.
// Optional feature macro: CLKDIV_DUTY_EN (programmable high time per channel).
package multi_clkdiv_pkg;

  localparam int CNT_W   = 26;
  localparam int DEF_DIV = 59999999;
  localparam int CFG_W   = CNT_W;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] hi;
  } clkdiv_cfg_t;

  // A divisor of zero would make a one-cycle period with no low phase; force 1.
  function automatic logic [CFG_W-1:0] clamp_div(input logic [CFG_W-1:0] div);
    return (div == '0) ? CFG_W'(1) : div;
  endfunction

  // Half of the period, rounded down; computed one bit wider so div=all-ones cannot wrap.
  function automatic logic [CFG_W-1:0] half_hi(input logic [CFG_W-1:0] div);
    logic [CFG_W:0] per;
    per = {1'b0, div} + {{CFG_W{1'b0}}, 1'b1};
    return CFG_W'(per >> 1);
  endfunction

  // Clamp applied when a shadow config becomes active. hi=0 (always low) and
  // hi>div (always high) fall out of the cnt<hi compare without modification.
  function automatic clkdiv_cfg_t clamp_cfg(input clkdiv_cfg_t c);
    clkdiv_cfg_t r;
    r.div = clamp_div(c.div);
    r.hi  = c.hi;
    return r;
  endfunction

endpackage

// File: rtl/multi_clk_divider_if.sv
// Config write port of the multi-channel clock divider (valid/ready).
// cfg_hi is only consumed when CLKDIV_DUTY_EN is defined.
interface multi_clk_divider_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = multi_clkdiv_pkg::CNT_W
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_hi;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_hi,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_hi,
    output cfg_ready
  );

endinterface

// File: rtl/multi_clk_divider_channel.sv
// One divider channel: counter, shadow/active config, pend flag, output regs.
// Optional feature macro: CLKDIV_DUTY_EN (stores a programmable high time;
// otherwise the high time is half the period, low-biased for odd periods).
module clkdiv_channel #(
  parameter int CNT_W   = multi_clkdiv_pkg::CNT_W,
  parameter int DEF_DIV = multi_clkdiv_pkg::DEF_DIV
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          wr,
  input  multi_clkdiv_pkg::clkdiv_cfg_t wr_cfg,
  output logic                          div_out,
  output logic                          tick,
  output logic                          pend
);
  import multi_clkdiv_pkg::*;

  localparam logic [CNT_W-1:0] DEF_D  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_HI = CNT_W'((64'(DEF_DIV) + 64'd1) >> 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_a;
  logic [CNT_W-1:0] hi_a;
  logic [CNT_W-1:0] load_div;
  logic             wrap;
  logic             apply;

  assign wrap  = (cnt == div_a);
  // Disabled channels take the shadow right away so a pending write never stalls.
  assign apply = pend && (!en || wrap);

`ifdef CLKDIV_DUTY_EN
  clkdiv_cfg_t      shadow;
  clkdiv_cfg_t      load_cfg;
  logic [CNT_W-1:0] hi_r;

  assign load_cfg = clamp_cfg(shadow);
  assign load_div = CNT_W'(load_cfg.div);
  assign hi_a     = hi_r;
`else
  logic [CNT_W-1:0] div_s;
  logic             unused_hi;

  assign load_div  = CNT_W'(clamp_div(CFG_W'(div_s)));
  assign hi_a      = CNT_W'(half_hi(CFG_W'(div_a)));
  assign unused_hi = ^wr_cfg.hi;
`endif

  // Shadow capture on accept, shadow-to-active transfer at the period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= 1'b0;
      div_a <= DEF_D;
`ifdef CLKDIV_DUTY_EN
      shadow <= '{div: CFG_W'(DEF_D), hi: CFG_W'(DEF_HI)};
      hi_r   <= DEF_HI;
`else
      div_s  <= DEF_D;
`endif
    end else if (wr) begin
`ifdef CLKDIV_DUTY_EN
      shadow <= wr_cfg;
`else
      div_s  <= CNT_W'(wr_cfg.div);
`endif
      pend <= 1'b1;
    end else if (apply) begin
      div_a <= load_div;
`ifdef CLKDIV_DUTY_EN
      hi_r  <= CNT_W'(load_cfg.hi);
`endif
      pend  <= 1'b0;
    end
  end

  // Period counter with registered waveform and wrap tick; disable restarts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      div_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      div_out <= (cnt < hi_a);
      tick    <= wrap;
      cnt     <= wrap ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider top: config decode, ready mux and
// CHANNELS independent divider channels.
// Optional feature macro: CLKDIV_DUTY_EN (per-channel programmable high time).
module multi_clk_divider #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = multi_clkdiv_pkg::CNT_W,
  parameter int DEF_DIV  = multi_clkdiv_pkg::DEF_DIV
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] ch_en,
  multi_clk_divider_if.slave  bus,
  output logic [CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0] period_tick,
  output logic [CHANNELS-1:0] pending
);
  import multi_clkdiv_pkg::*;

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] wr;
  logic                ready;
  clkdiv_cfg_t         wr_cfg;

  // Ready follows the addressed channel's pend flag; unknown channels always accept.
  always_comb begin
    ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.cfg_ch == CH_W'(i)) ready = !pending[i];
    end
  end

  assign bus.cfg_ready = ready;
  assign wr_cfg        = '{div: CFG_W'(bus.cfg_div), hi: CFG_W'(bus.cfg_hi)};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign wr[g] = bus.cfg_valid && ready && (bus.cfg_ch == CH_W'(g));

    clkdiv_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[g]),
      .wr      (wr[g]),
      .wr_cfg  (wr_cfg),
      .div_out (div_out[g]),
      .tick    (period_tick[g]),
      .pend    (pending[g])
    );
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed bench for multi_clk_divider: reset state, vector table of divisor/high
// settings on channel 1, mid-period reprogramming, enable toggling, reset with pend.
module tb_multi_clk_divider;
  localparam int CH = 4;
  localparam int W  = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] div_out;
  logic [CH-1:0] period_tick;
  logic [CH-1:0] pending;

  int checks   = 0;
  int failures = 0;

  multi_clk_divider_if #(.CHANNELS(CH), .CNT_W(W)) bus();

  multi_clk_divider #(
    .CHANNELS (CH),
    .CNT_W    (W),
    .DEF_DIV  (59999999)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_en       (ch_en),
    .bus         (bus),
    .div_out     (div_out),
    .period_tick (period_tick),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] div;
    logic [W-1:0] hi;
    int           per;
    int           hi_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load ch1 while disabled: accept, pend for one cycle, applied, then enable.
  task automatic load_vec(input logic [W-1:0] div, input logic [W-1:0] hi);
    @(negedge clk);
    ch_en[1]      = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'd1;
    bus.cfg_div   = div;
    bus.cfg_hi    = hi;
    #1 chk1("load_ready", bus.cfg_ready, 1'b1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk1("load_pending_set", pending[1], 1'b1);
    chk1("load_disabled_out", div_out[1], 1'b0);
    @(negedge clk);
    chk1("load_pending_clr", pending[1], 1'b0);
    ch_en[1] = 1'b1;
  endtask

  // Sample n cycles of ch1; k counts cycles since cnt was 0.
  task automatic run(input string tag, input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk1({tag, "_div_out"}, div_out[1], (k % per) < hi);
      chk1({tag, "_tick"}, period_tick[1], (k % per) == per - 1);
    end
  endtask

  initial begin
`ifdef CLKDIV_DUTY_EN
    vecs[0] = '{26'd3, 26'd2, 4, 2};
    vecs[1] = '{26'd0, 26'd0, 2, 0};
    vecs[2] = '{26'd4, 26'd7, 5, 5};
    vecs[3] = '{26'd5, 26'd3, 6, 3};
    vecs[4] = '{26'd1, 26'd1, 2, 1};
    vecs[5] = '{26'd6, 26'd2, 7, 2};
`else
    vecs[0] = '{26'd3, 26'd2, 4, 2};
    vecs[1] = '{26'd0, 26'd0, 2, 1};
    vecs[2] = '{26'd4, 26'd7, 5, 2};
    vecs[3] = '{26'd5, 26'd3, 6, 3};
    vecs[4] = '{26'd1, 26'd1, 2, 1};
    vecs[5] = '{26'd6, 26'd2, 7, 3};
`endif

    rst           = 1'b1;
    ch_en         = '1;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_div   = '0;
    bus.cfg_hi    = '0;

    // Reset held with all channels enabled.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk4("rst_div_out", div_out, '0);
      chk4("rst_tick", period_tick, '0);
      chk4("rst_pending", pending, '0);
    end
    rst = 1'b0;

    // Default divisor: high for the first half of a 60M-cycle period, no tick.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk4("def_div_out", div_out, '1);
      chk4("def_tick", period_tick, '0);
    end

    for (int v = 0; v < 6; v++) begin
      load_vec(vecs[v].div, vecs[v].hi);
      run($sformatf("vec%0d", v), vecs[v].per, vecs[v].hi_cnt, 2 * vecs[v].per);
    end

    // Mid-period rewrite: div=9 running, write div=1 at cnt=3.
    load_vec(26'd9, 26'd5);
    run("mid_old", 10, 5, 4);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'd1;
    bus.cfg_div   = 26'd1;
    bus.cfg_hi    = 26'd1;
    #1 chk1("mid_ready_before", bus.cfg_ready, 1'b1);
    for (int k = 4; k < 9; k++) begin
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      #1;
      chk1("mid_pending", pending[1], 1'b1);
      chk1("mid_ready_low", bus.cfg_ready, 1'b0);
      chk1("mid_div_out", div_out[1], k < 5);
      chk1("mid_tick", period_tick[1], 1'b0);
      if (k == 4) begin
        bus.cfg_ch = 2'd2;
        #1 chk1("mid_other_ready", bus.cfg_ready, 1'b1);
        bus.cfg_ch = 2'd1;
      end
    end
    @(negedge clk);
    #1;
    chk1("mid_wrap_tick", period_tick[1], 1'b1);
    chk1("mid_wrap_out", div_out[1], 1'b0);
    chk1("mid_wrap_pending", pending[1], 1'b0);
    chk1("mid_wrap_ready", bus.cfg_ready, 1'b1);
    run("mid_new", 2, 1, 6);

    // Disable mid-period, then re-enable: fresh period with no partial pulse.
    @(negedge clk);
    ch_en[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1("dis_div_out", div_out[1], 1'b0);
      chk1("dis_tick", period_tick[1], 1'b0);
    end
    ch_en[1] = 1'b1;
    run("reen", 2, 1, 4);

    // Reset mid-period with a pending write: everything back to defaults.
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 26'd9;
    bus.cfg_hi    = 26'd5;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk1("rst2_pending_set", pending[1], 1'b1);
    rst = 1'b1;
    #1;
    chk4("rst2_div_out", div_out, '0);
    chk4("rst2_tick", period_tick, '0);
    chk4("rst2_pending", pending, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk1("rst2_def_out", div_out[1], 1'b1);
      chk1("rst2_def_tick", period_tick[1], 1'b0);
      chk1("rst2_def_pending", pending[1], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
